// File: rtl/soc1_sysid_timer.sv
// System ID / build timestamp block with a prescaled 64-bit uptime counter and scratch registers.
// The uptime counter is read LO-first: a LO read latches HI into a shadow, so the pair stays coherent.
module soc1_sysid_timer #(
  parameter logic [31:0] ID_VALUE     = 32'h672380AE,
  parameter logic [31:0] TIMESTAMP    = 32'h00000000,
  parameter int          NUM_SCRATCH  = 4,
  parameter logic [31:0] PRESCALE_RST = 32'd49,
  localparam int         ADDR_W       = $clog2(6 + NUM_SCRATCH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam logic [ADDR_W-1:0] A_ID  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TS  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_LO  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_HI  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_CTL = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_PRE = ADDR_W'(5);

  logic        en_q, en_d;
  logic [31:0] prescale_q, prescale_d;
  logic [31:0] cnt_q, cnt_d;
  logic [63:0] uptime_q, uptime_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] scratch_q [NUM_SCRATCH];
  logic [31:0] scratch_d [NUM_SCRATCH];
  logic [31:0] readdata_q, readdata_d;
  logic        rdv_q, rdv_d;

  logic        rd_acc;
  logic        wr_ctl;
  logic        wr_pre;
  logic        clr;
  logic        tick;
  logic [31:0] rmux;

  // Write wins over a simultaneous read; the read is simply not accepted.
  assign rd_acc = read & ~write;
  assign wr_ctl = write && (address == A_CTL);
  assign wr_pre = write && (address == A_PRE);
  assign clr    = wr_ctl & writedata[1];
  assign tick   = en_q && (cnt_q == prescale_q);

  always_comb begin
    en_d       = en_q;
    prescale_d = prescale_q;
    cnt_d      = cnt_q;
    uptime_d   = uptime_q;
    scratch_d  = scratch_q;

    if (wr_ctl) en_d = writedata[0];
    if (wr_pre) prescale_d = writedata;

    if (en_q) cnt_d = tick ? 32'd0 : cnt_q + 32'd1;
    if (clr || wr_pre) cnt_d = 32'd0;

    if (tick) uptime_d = uptime_q + 64'd1;
    if (clr) uptime_d = 64'd0;

    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (write && (address == ADDR_W'(6 + i))) scratch_d[i] = writedata;
    end
  end

  always_comb begin
    rmux = 32'd0;
    case (address)
      A_ID:    rmux = ID_VALUE;
      A_TS:    rmux = TIMESTAMP;
      A_LO:    rmux = uptime_q[31:0];
      A_HI:    rmux = shadow_q;
      A_CTL:   rmux = {31'd0, en_q};
      A_PRE:   rmux = prescale_q;
      default: rmux = 32'd0;
    endcase
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (address == ADDR_W'(6 + i)) rmux = scratch_q[i];
    end
  end

  always_comb begin
    shadow_d   = shadow_q;
    readdata_d = readdata_q;
    rdv_d      = rd_acc;
    if (rd_acc) begin
      readdata_d = rmux;
      if (address == A_LO) shadow_d = uptime_q[63:32];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      en_q       <= 1'b0;
      prescale_q <= PRESCALE_RST;
      cnt_q      <= 32'd0;
      uptime_q   <= 64'd0;
      shadow_q   <= 32'd0;
      readdata_q <= 32'd0;
      rdv_q      <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= 32'd0;
    end else begin
      en_q       <= en_d;
      prescale_q <= prescale_d;
      cnt_q      <= cnt_d;
      uptime_q   <= uptime_d;
      shadow_q   <= shadow_d;
      readdata_q <= readdata_d;
      rdv_q      <= rdv_d;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= scratch_d[i];
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rdv_q;

endmodule
